// File: rtl/memory_arbiter.sv
// Two-port memory arbiter: instruction fetch and load/store ports share one
// single-cycle-latency memory, with round-robin or data-first arbitration.
module memory_arbiter #(
    parameter int DATA_PRIORITY = 0
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        fetch_request_i,
    input  logic [31:0] fetch_address_i,
    output logic        fetch_grant_o,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_data_o,
    input  logic        data_request_i,
    input  logic        data_write_i,
    input  logic [31:0] data_address_i,
    input  logic [31:0] data_write_data_i,
    input  logic [3:0]  data_byte_enable_i,
    output logic        data_grant_o,
    output logic        data_valid_o,
    output logic [31:0] data_read_data_o,
    output logic        read_enable_o,
    output logic        write_enable_o,
    output logic [31:0] address_o,
    output logic [31:0] write_data_o,
    output logic [3:0]  byte_enable_o,
    input  logic [31:0] data_i
);

    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_FETCH = 2'd1,
        OWNER_DATA  = 2'd2
    } owner_t;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_t;

    owner_t      owner_q, owner_d;
    port_t       last_grant_q, last_grant_d;
    logic        fetch_win;
    logic        data_win;
    logic [31:0] granted_address;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        fetch_win = 1'b0;
        data_win  = 1'b0;
        if (!reset_i) begin
            if (fetch_request_i && data_request_i) begin
                if (DATA_PRIORITY != 0) begin
                    data_win = 1'b1;
                end else if (last_grant_q == PORT_DATA) begin
                    fetch_win = 1'b1;
                end else begin
                    data_win = 1'b1;
                end
            end else begin
                fetch_win = fetch_request_i;
                data_win  = data_request_i;
            end
        end
    end

    always_comb begin
        read_enable_o   = 1'b0;
        write_enable_o  = 1'b0;
        byte_enable_o   = 4'b0000;
        write_data_o    = 32'd0;
        granted_address = 32'd0;
        owner_d         = OWNER_NONE;
        last_grant_d    = last_grant_q;
        if (fetch_win) begin
            read_enable_o   = 1'b1;
            granted_address = fetch_address_i;
            owner_d         = OWNER_FETCH;
            last_grant_d    = PORT_FETCH;
        end else if (data_win) begin
            granted_address = data_address_i;
            owner_d         = OWNER_DATA;
            last_grant_d    = PORT_DATA;
            if (data_write_i) begin
                write_enable_o = 1'b1;
                byte_enable_o  = data_byte_enable_i;
                write_data_o   = data_write_data_i;
            end else begin
                read_enable_o = 1'b1;
            end
        end
    end

    // Memory is word addressed; byte offset is dropped, lanes come from byte_enable_o.
    assign address_o     = granted_address & 32'hFFFF_FFFC;
    assign fetch_grant_o = fetch_win;
    assign data_grant_o  = data_win;

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            owner_q      <= OWNER_NONE;
            last_grant_q <= PORT_DATA;
        end else begin
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign fetch_valid_o    = (owner_q == OWNER_FETCH);
    assign data_valid_o     = (owner_q == OWNER_DATA);
    assign fetch_data_o     = data_i;
    assign data_read_data_o = data_i;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: one round-robin and one data-priority
// instance share stimulus and are compared against a transaction-level model.
module tb_memory_arbiter;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        fetch_request_i = 1'b0;
    logic [31:0] fetch_address_i = 32'd0;
    logic        data_request_i = 1'b0;
    logic        data_write_i = 1'b0;
    logic [31:0] data_address_i = 32'd0;
    logic [31:0] data_write_data_i = 32'd0;
    logic [3:0]  data_byte_enable_i = 4'd0;
    logic [31:0] data_i = 32'd0;

    logic        fg[2];
    logic        fv[2];
    logic [31:0] fdat[2];
    logic        dg[2];
    logic        dv[2];
    logic [31:0] ddat[2];
    logic        re[2];
    logic        we[2];
    logic [31:0] addr[2];
    logic [31:0] wd[2];
    logic [3:0]  be[2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model state: 0 = none, 1 = fetch, 2 = data
    int m_last[2];
    int m_owner[2];
    int last_w[2];

    memory_arbiter #(.DATA_PRIORITY(0)) dut_rr (
        .clock_i(clock_i), .reset_i(reset_i),
        .fetch_request_i(fetch_request_i), .fetch_address_i(fetch_address_i),
        .fetch_grant_o(fg[0]), .fetch_valid_o(fv[0]), .fetch_data_o(fdat[0]),
        .data_request_i(data_request_i), .data_write_i(data_write_i),
        .data_address_i(data_address_i), .data_write_data_i(data_write_data_i),
        .data_byte_enable_i(data_byte_enable_i),
        .data_grant_o(dg[0]), .data_valid_o(dv[0]), .data_read_data_o(ddat[0]),
        .read_enable_o(re[0]), .write_enable_o(we[0]), .address_o(addr[0]),
        .write_data_o(wd[0]), .byte_enable_o(be[0]), .data_i(data_i)
    );

    memory_arbiter #(.DATA_PRIORITY(1)) dut_dp (
        .clock_i(clock_i), .reset_i(reset_i),
        .fetch_request_i(fetch_request_i), .fetch_address_i(fetch_address_i),
        .fetch_grant_o(fg[1]), .fetch_valid_o(fv[1]), .fetch_data_o(fdat[1]),
        .data_request_i(data_request_i), .data_write_i(data_write_i),
        .data_address_i(data_address_i), .data_write_data_i(data_write_data_i),
        .data_byte_enable_i(data_byte_enable_i),
        .data_grant_o(dg[1]), .data_valid_o(dv[1]), .data_read_data_o(ddat[1]),
        .read_enable_o(re[1]), .write_enable_o(we[1]), .address_o(addr[1]),
        .write_data_o(wd[1]), .byte_enable_o(be[1]), .data_i(data_i)
    );

    always #5 clock_i = ~clock_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // Who gets the memory this cycle under instance p's arbitration rule.
    function automatic int winner(int p);
        if (reset_i) return 0;
        if (fetch_request_i && data_request_i) begin
            if (p == 1) return 2;
            return (m_last[p] == 2) ? 1 : 2;
        end
        if (fetch_request_i) return 1;
        if (data_request_i) return 2;
        return 0;
    endfunction

    task automatic tick();
        int w[2];
        for (int p = 0; p < 2; p++) w[p] = winner(p);
        @(posedge clock_i);
        for (int p = 0; p < 2; p++) begin
            m_owner[p] = w[p];
            last_w[p]  = w[p];
            if (w[p] != 0) m_last[p] = w[p];
        end
        #1;
        cyc++;
    endtask

    task automatic idle();
        fetch_request_i = 1'b0;
        data_request_i  = 1'b0;
        data_write_i    = 1'b0;
    endtask

    task automatic apply_reset();
        idle();
        reset_i = 1'b1;
        for (int p = 0; p < 2; p++) begin
            m_last[p]  = 2;
            m_owner[p] = 0;
            last_w[p]  = 0;
        end
        repeat (2) tick();
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i            = 1'b1;
        fetch_request_i    = 1'b1;
        data_request_i     = 1'b1;
        data_write_i       = 1'b1;
        fetch_address_i    = $urandom;
        data_address_i     = $urandom;
        data_write_data_i  = $urandom | 32'h1;
        data_byte_enable_i = 4'hF;
        @(negedge clock_i);
        for (int p = 0; p < 2; p++) begin
            checks++;
            if ({fg[p], dg[p], fv[p], dv[p], re[p], we[p], be[p], addr[p], wd[p]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs p=%0d got fg=%b dg=%b fv=%b dv=%b re=%b we=%b be=%h addr=%h wd=%h exp all zero",
                         p, fg[p], dg[p], fv[p], dv[p], re[p], we[p], be[p], addr[p], wd[p]);
            end
        end
        apply_reset();
    endtask

    task automatic test_fetch_only();
        logic [31:0] rd;
        apply_reset();
        fetch_request_i = 1'b1;
        fetch_address_i = 32'h0000_0104;
        @(negedge clock_i);
        checks++;
        if ({fg[0], dg[0], re[0], we[0]} !== 4'b1010 || addr[0] !== 32'h0000_0104 ||
            be[0] !== 4'b0000 || wd[0] !== 32'd0) begin
            errors++;
            $display("FAIL fetch_cmd got fg=%b dg=%b re=%b we=%b addr=%h be=%b wd=%h exp 1 0 1 0 00000104 0000 0",
                     fg[0], dg[0], re[0], we[0], addr[0], be[0], wd[0]);
        end
        checks++;
        if (fg[1] !== 1'b1) begin
            errors++;
            $display("FAIL fetch_only_dp got fg=%b exp 1", fg[1]);
        end
        tick();
        idle();
        rd     = $urandom;
        data_i = rd;
        @(negedge clock_i);
        checks++;
        if (fv[0] !== 1'b1 || dv[0] !== 1'b0 || fdat[0] !== rd) begin
            errors++;
            $display("FAIL fetch_resp got fv=%b dv=%b data=%h exp 1 0 %h", fv[0], dv[0], fdat[0], rd);
        end
        checks++;
        if (fg[0] !== 1'b0 || re[0] !== 1'b0 || addr[0] !== 32'd0) begin
            errors++;
            $display("FAIL fetch_idle got fg=%b re=%b addr=%h exp 0 0 0", fg[0], re[0], addr[0]);
        end
        tick();
    endtask

    task automatic test_alternate();
        apply_reset();
        fetch_request_i = 1'b1;
        fetch_address_i = 32'h0000_1000;
        data_request_i  = 1'b1;
        data_write_i    = 1'b0;
        data_address_i  = 32'h0000_2008;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock_i);
            checks++;
            if (fg[0] !== (k % 2 == 0) || dg[0] !== (k % 2 == 1)) begin
                errors++;
                $display("FAIL alt_grant k=%0d got fg=%b dg=%b exp %0d %0d", k, fg[0], dg[0], k % 2 == 0, k % 2 == 1);
            end
            checks++;
            if (fv[0] !== (k > 0 && (k - 1) % 2 == 0) || dv[0] !== (k > 0 && (k - 1) % 2 == 1)) begin
                errors++;
                $display("FAIL alt_valid k=%0d got fv=%b dv=%b", k, fv[0], dv[0]);
            end
            checks++;
            if (dg[1] !== 1'b1 || fg[1] !== 1'b0 || dv[1] !== (k > 0) || fv[1] !== 1'b0) begin
                errors++;
                $display("FAIL prio_data k=%0d got dg=%b fg=%b dv=%b fv=%b exp 1 0 %0d 0", k, dg[1], fg[1], dv[1], fv[1], k > 0);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_store();
        apply_reset();
        data_request_i     = 1'b1;
        data_write_i       = 1'b1;
        data_address_i     = 32'h0000_0203;
        data_byte_enable_i = 4'b0010;
        data_write_data_i  = 32'hAABB_CCDD;
        @(negedge clock_i);
        checks++;
        if ({dg[0], we[0], re[0]} !== 3'b110 || addr[0] !== 32'h0000_0200 ||
            be[0] !== 4'b0010 || wd[0] !== 32'hAABB_CCDD) begin
            errors++;
            $display("FAIL store_cmd got dg=%b we=%b re=%b addr=%h be=%b wd=%h exp 1 1 0 00000200 0010 aabbccdd",
                     dg[0], we[0], re[0], addr[0], be[0], wd[0]);
        end
        tick();
        idle();
        @(negedge clock_i);
        checks++;
        if (dv[0] !== 1'b1 || fv[0] !== 1'b0 || we[0] !== 1'b0) begin
            errors++;
            $display("FAIL store_ack got dv=%b fv=%b we=%b exp 1 0 0", dv[0], fv[0], we[0]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            fetch_request_i = 1'b1;
            fetch_address_i = 32'h0000_0400 + 32'(4 * k);
            @(negedge clock_i);
            checks++;
            if (fg[0] !== 1'b1 || fv[0] !== (k > 0) || addr[0] !== 32'h0000_0400 + 32'(4 * k)) begin
                errors++;
                $display("FAIL b2b k=%0d got fg=%b fv=%b addr=%h", k, fg[0], fv[0], addr[0]);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_outstanding();
        apply_reset();
        fetch_request_i = 1'b1;
        fetch_address_i = 32'h0000_0040;
        @(negedge clock_i);
        checks++;
        if (fg[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_grant got fg=%b exp 1", fg[0]);
        end
        tick();
        idle();
        reset_i = 1'b1;
        for (int p = 0; p < 2; p++) begin
            m_owner[p] = 0;
            m_last[p]  = 2;
        end
        #1;
        checks++;
        if (fv[0] !== 1'b0 || fv[1] !== 1'b0) begin
            errors++;
            $display("FAIL rst_discard got fv=%b%b exp 00", fv[0], fv[1]);
        end
        tick();
        reset_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock_i);
            for (int p = 0; p < 2; p++) begin
                checks++;
                if ({fg[p], dg[p], fv[p], dv[p], re[p], we[p], be[p], addr[p], wd[p]} !== '0) begin
                    errors++;
                    $display("FAIL rst_after k=%0d p=%0d got fg=%b dg=%b fv=%b dv=%b re=%b we=%b exp all zero",
                             k, p, fg[p], dg[p], fv[p], dv[p], re[p], we[p]);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        int          w;
        logic [31:0] rd;
        logic [31:0] exp_addr;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            // Requests hold their fields until the round-robin instance grants them.
            if (!fetch_request_i || last_w[0] == 1) begin
                fetch_request_i = ($urandom_range(0, 2) != 0);
                fetch_address_i = $urandom;
            end
            if (!data_request_i || last_w[0] == 2) begin
                data_request_i     = ($urandom_range(0, 2) != 0);
                data_write_i       = $urandom_range(0, 1) == 1;
                data_address_i     = $urandom;
                data_write_data_i  = $urandom;
                data_byte_enable_i = 4'($urandom);
            end
            rd     = $urandom;
            data_i = rd;
            @(negedge clock_i);
            for (int p = 0; p < 2; p++) begin
                w        = winner(p);
                exp_addr = (w == 1) ? (fetch_address_i / 4) * 4 :
                           (w == 2) ? (data_address_i / 4) * 4 : 32'd0;
                checks++;
                if (fg[p] !== (w == 1) || dg[p] !== (w == 2)) begin
                    errors++;
                    $display("FAIL rnd_grant p=%0d cyc=%0d got fg=%b dg=%b exp winner=%0d", p, cyc, fg[p], dg[p], w);
                end
                checks++;
                if (re[p] !== (w == 1 || (w == 2 && !data_write_i)) || we[p] !== (w == 2 && data_write_i)) begin
                    errors++;
                    $display("FAIL rnd_strobe p=%0d cyc=%0d got re=%b we=%b winner=%0d write=%b", p, cyc, re[p], we[p], w, data_write_i);
                end
                checks++;
                if (addr[p] !== exp_addr) begin
                    errors++;
                    $display("FAIL rnd_addr p=%0d cyc=%0d got %h exp %h", p, cyc, addr[p], exp_addr);
                end
                checks++;
                if (be[p] !== ((w == 2 && data_write_i) ? data_byte_enable_i : 4'b0000)) begin
                    errors++;
                    $display("FAIL rnd_be p=%0d cyc=%0d got %b", p, cyc, be[p]);
                end
                if (!(w == 2 && !data_write_i)) begin
                    checks++;
                    if (wd[p] !== ((w == 2) ? data_write_data_i : 32'd0)) begin
                        errors++;
                        $display("FAIL rnd_wdata p=%0d cyc=%0d got %h", p, cyc, wd[p]);
                    end
                end
                checks++;
                if (fv[p] !== (m_owner[p] == 1) || dv[p] !== (m_owner[p] == 2)) begin
                    errors++;
                    $display("FAIL rnd_valid p=%0d cyc=%0d got fv=%b dv=%b exp owner=%0d", p, cyc, fv[p], dv[p], m_owner[p]);
                end
                checks++;
                if (fdat[p] !== rd || ddat[p] !== rd) begin
                    errors++;
                    $display("FAIL rnd_rdata p=%0d cyc=%0d got %h %h exp %h", p, cyc, fdat[p], ddat[p], rd);
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_alternate();
        test_store();
        test_back_to_back();
        test_reset_outstanding();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter DATA_PRIORITY, default 0, selects arbitration: 0 = round-robin, 1 = data port always wins.
REQ-002 clock_i  input  1  single clock; all state updates on rising edge.
REQ-003 reset_i  input  1  asynchronous, active-high reset.
REQ-004 fetch_request_i  input  1  instruction fetch request; held until granted.
REQ-005 fetch_address_i  input  32  fetch byte address.
REQ-006 fetch_grant_o  output  1  fetch request accepted this cycle.
REQ-007 fetch_valid_o  output  1  fetch read data valid this cycle.
REQ-008 fetch_data_o  output  32  fetch read data.
REQ-009 data_request_i  input  1  load/store request; held with its fields until granted.
REQ-010 data_write_i  input  1  1 = store, 0 = load.
REQ-011 data_address_i  input  32  load/store byte address.
REQ-012 data_write_data_i  input  32  store data.
REQ-013 data_byte_enable_i  input  4  store byte lanes.
REQ-014 data_grant_o  output  1  data request accepted this cycle.
REQ-015 data_valid_o  output  1  load data valid or store acknowledged.
REQ-016 data_read_data_o  output  32  load data.
REQ-017 read_enable_o  output  1  memory read strobe.
REQ-018 write_enable_o  output  1  memory write strobe.
REQ-019 address_o  output  32  memory word address.
REQ-020 write_data_o  output  32  memory write data.
REQ-021 byte_enable_o  output  4  memory write byte lanes.
REQ-022 data_i  input  32  memory read data, valid one cycle after read_enable_o.

Function
REQ-023 Grants are combinational from current requests and registered state; at most one grant per cycle.
REQ-024 Single request: that requester is granted the same cycle.
REQ-025 Both requesting, DATA_PRIORITY=0: grant the port not granted most recently (last_grant register); DATA_PRIORITY=1: grant data.
REQ-026 last_grant updates on every grant; it is unchanged in cycles with no grant.
REQ-027 In a grant cycle the memory command is driven combinationally: address_o = {granted_address[31:2], 2'b00}.
REQ-028 Fetch grant: read_enable_o=1, write_enable_o=0, byte_enable_o=4'b0000, write_data_o=0.
REQ-029 Data load grant: read_enable_o=1, write_enable_o=0, byte_enable_o=4'b0000.
REQ-030 Data store grant: write_enable_o=1, read_enable_o=0, byte_enable_o=data_byte_enable_i, write_data_o=data_write_data_i.
REQ-031 No grant: read_enable_o, write_enable_o, byte_enable_o, address_o, write_data_o all zero.
REQ-032 Response owner register (NONE/FETCH/DATA) captures the grantee each cycle; response latency is exactly 1 cycle after grant.
REQ-033 fetch_valid_o=1 iff owner=FETCH; data_valid_o=1 iff owner=DATA (stores included).
REQ-034 fetch_data_o and data_read_data_o both equal data_i unconditionally; only the valid signals qualify them.
REQ-035 Back-to-back: a grant and a response for the same or the other port in the same cycle are legal; full throughput is one transfer per cycle.
REQ-036 Sustained dual requests with DATA_PRIORITY=0 alternate grants strictly; neither port waits more than one cycle.

Reset
REQ-037 While reset_i is high: last_grant=DATA (fetch wins the first tie), owner=NONE, all valid and grant outputs 0, all memory outputs 0.
REQ-038 Reset asserted with a response outstanding discards it; no valid is issued after reset release.

Verification
REQ-039 Fetch only, fetch_address_i=0x00000104 -> same-cycle fetch_grant_o=1, read_enable_o=1, address_o=0x00000104; next cycle fetch_valid_o=1, fetch_data_o=data_i.
REQ-040 Both request continuously from reset, DATA_PRIORITY=0 -> grants F,D,F,D; valids follow one cycle later in the same order.
REQ-041 Both request, DATA_PRIORITY=1 -> data_grant_o=1 every cycle; fetch_grant_o stays 0.
REQ-042 Store, address 0x00000203, byte_enable 4'b0010, data 0xAABBCCDD -> write_enable_o=1, address_o=0x00000200, byte_enable_o=4'b0010; next cycle data_valid_o=1.
REQ-043 Reset pulsed the cycle after a fetch grant -> fetch_valid_o stays 0; all outputs 0 until the next request.
